// File: rtl/clock_div_pkg.sv
// clock_div_pkg: default divider configuration and half-period terminal helper
package clock_div_pkg;
  localparam int DEFAULT_DIVIDE = 100000;
  localparam int DEFAULT_CNT_W = 17;
  function automatic int half_term(input int divide);
    return divide / 2 - 1;
  endfunction
endpackage

// File: rtl/clock_div_1mhz_10hz.sv
// clock_div_1mhz_10hz: divide CLK_1MHZ_IN by DIVIDE into a 50% duty flop clock; CLOCK_DIV_TICK_EN adds TICK_OUT
module clock_div_1mhz_10hz
  import clock_div_pkg::*;
#(
  parameter int DIVIDE = DEFAULT_DIVIDE,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input logic CLK_1MHZ_IN,
  input logic RESET,
  output logic CLK_10HZ_OUT,
  output logic [CNT_W-1:0] counter
`ifdef CLOCK_DIV_TICK_EN
  ,
  output logic TICK_OUT
`endif
);
  if (DIVIDE < 2 || DIVIDE % 2 != 0 || ((longint'(DIVIDE) - 1) >> CNT_W) != 0) begin : g_bad_cfg
    $error("clock_div_1mhz_10hz: DIVIDE must be even, >= 2 and DIVIDE-1 must fit in CNT_W bits");
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(half_term(DIVIDE));
  // count 0..DIVIDE-1 and wrap explicitly
  always_ff @(posedge CLK_1MHZ_IN)
    counter <= RESET || counter == LAST ? '0 : counter + CNT_W'(1);
  // rise entering the upper half, fall on the wrap, hold otherwise
  always_ff @(posedge CLK_1MHZ_IN)
    CLK_10HZ_OUT <= RESET ? 1'b0 : counter == HALF ? 1'b1 : counter == LAST ? 1'b0 : CLK_10HZ_OUT;
`ifdef CLOCK_DIV_TICK_EN
  // one-cycle pulse aligned with counter returning to zero after a wrap
  always_ff @(posedge CLK_1MHZ_IN)
    TICK_OUT <= !RESET && counter == LAST;
`endif
endmodule

// File: tb/tb_clock_div_1mhz_10hz.sv
// tb_clock_div_1mhz_10hz: directed checks of the divider (DIVIDE=1000 and DIVIDE=4 instances)
module tb_clock_div_1mhz_10hz;
  localparam int D = 1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_out, s_out, tick;
  logic [9:0] cnt;
  logic [1:0] s_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  always #500 clk = ~clk;
  clock_div_1mhz_10hz #(.DIVIDE(D), .CNT_W(10)) u_dut (
    .CLK_1MHZ_IN(clk),
    .RESET(rst),
    .CLK_10HZ_OUT(clk_out),
    .counter(cnt)
`ifdef CLOCK_DIV_TICK_EN
    ,
    .TICK_OUT(tick)
`endif
  );
  clock_div_1mhz_10hz #(.DIVIDE(4), .CNT_W(2)) u_small (
    .CLK_1MHZ_IN(clk),
    .RESET(rst),
    .CLK_10HZ_OUT(s_out),
    .counter(s_cnt)
`ifdef CLOCK_DIV_TICK_EN
    ,
    .TICK_OUT()
`endif
  );
`ifndef CLOCK_DIV_TICK_EN
  assign tick = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    k = rst ? 0 : k + 1;
  endtask
  task automatic run_to(input int target);
    int n;
    n = (target - k % D + D) % D;
    repeat (n) step();
  endtask
  initial begin
    int hi, lo, ticks, guard;
    repeat (10) step();
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_out", 32'(clk_out), 0);
    chk("rst_small_cnt", 32'(s_cnt), 0);
    chk("rst_small_out", 32'(s_out), 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("post_cnt", 32'(cnt), i);
      chk("post_out", 32'(clk_out), 0);
      chk("post_tick", 32'(tick), 0);
      chk("small_cnt", 32'(s_cnt), i % 4);
      chk("small_out", 32'(s_out), (i % 4) >= 2 ? 1 : 0);
    end
    run_to(499);
    chk("pre_half_cnt", 32'(cnt), 499);
    chk("pre_half_out", 32'(clk_out), 0);
    step();
    chk("half_cnt", 32'(cnt), 500);
    chk("half_out", 32'(clk_out), 1);
    run_to(999);
    chk("last_cnt", 32'(cnt), 999);
    chk("last_out", 32'(clk_out), 1);
    chk("last_tick", 32'(tick), 0);
    step();
    chk("wrap_cnt", 32'(cnt), 0);
    chk("wrap_out", 32'(clk_out), 0);
`ifdef CLOCK_DIV_TICK_EN
    chk("wrap_tick", 32'(tick), 1);
`endif
    step();
    chk("after_wrap_cnt", 32'(cnt), 1);
    chk("after_wrap_tick", 32'(tick), 0);
    run_to(500);
    chk("rise_out", 32'(clk_out), 1);
    ticks = 0;
    for (int p = 0; p < 10; p++) begin
      hi = 1;
      lo = 0;
      guard = 0;
      while (clk_out === 1'b1 && guard < 2 * D) begin
        step();
        guard++;
        ticks += (tick === 1'b1) ? 1 : 0;
        if (clk_out === 1'b1) hi++;
      end
      while (clk_out !== 1'b1 && guard < 2 * D) begin
        step();
        guard++;
        ticks += (tick === 1'b1) ? 1 : 0;
        lo++;
      end
      chk("period_high", 32'(hi), D / 2);
      chk("period_len", 32'(hi + lo), D);
    end
`ifdef CLOCK_DIV_TICK_EN
    chk("tick_count", 32'(ticks), 10);
`endif
    chk("period_end_cnt", 32'(cnt), 500);
    run_to(999);
    chk("mid_rst_pre_cnt", 32'(cnt), 999);
    rst = 1'b1;
    step();
    chk("rst_at_last_cnt", 32'(cnt), 0);
    chk("rst_at_last_out", 32'(clk_out), 0);
    chk("rst_at_last_tick", 32'(tick), 0);
    rst = 1'b0;
    run_to(499);
    chk("mid_rst_half_pre_cnt", 32'(cnt), 499);
    rst = 1'b1;
    step();
    chk("rst_at_half_cnt", 32'(cnt), 0);
    chk("rst_at_half_out", 32'(clk_out), 0);
    rst = 1'b0;
    step();
    chk("rerelease_cnt", 32'(cnt), 1);
    chk("rerelease_out", 32'(clk_out), 0);
    chk("rerelease_tick", 32'(tick), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_div_1mhz_10hz.md
CLOCK_DIV_1MHZ_10HZ -- requirements
Module: clock_div_1mhz_10hz

Interface
REQ-001 Parameters SHALL be, one per line:
- DIVIDE, default 100000, input clocks per output period; even, at least 2.
- CNT_W, default 17, counter width; 2^CNT_W must be at least DIVIDE.

REQ-002 Ports SHALL be, one per line:
- CLK_1MHZ_IN, input, 1, 1 MHz clock; the only clock.
- RESET, input, 1, synchronous active-high reset.
- CLK_10HZ_OUT, output, 1, divided clock (10 Hz at default DIVIDE).
- counter, output, CNT_W, current divider count.

REQ-003 One clock; reset is synchronous and active-high. All state SHALL update only on the rising edge of CLK_1MHZ_IN.

Function
REQ-004 counter SHALL increment by 1 on every rising edge while RESET is low.
REQ-005 counter SHALL wrap from DIVIDE-1 (99999) to 0 on the next edge.
REQ-006 counter SHALL never exceed DIVIDE-1 and SHALL never use modulo-2^CNT_W wrap.
REQ-007 CLK_10HZ_OUT SHALL be a registered output, updated at the edges below and otherwise held:
- set to 1 at the edge where counter advances from DIVIDE/2-1 (49999) to DIVIDE/2 (50000);
- cleared to 0 at the edge where counter wraps from DIVIDE-1 to 0.
REQ-008 As a result, CLK_10HZ_OUT SHALL be high exactly while counter is in [DIVIDE/2, DIVIDE-1]: 50% duty, period DIVIDE input cycles (100 ms at 1 MHz).
REQ-009 CLK_10HZ_OUT SHALL be glitch-free: a flop output with no combinational decode on the output path.
REQ-010 The counter port SHALL be the state register itself, with zero latency relative to CLK_10HZ_OUT.
REQ-011 Elaboration SHALL fail if DIVIDE is odd, DIVIDE is less than 2, or DIVIDE-1 does not fit in CNT_W bits.

Reset
REQ-012 While RESET is high at a rising edge, counter SHALL become 0 and CLK_10HZ_OUT SHALL become 0.
REQ-013 RESET asserted mid-period, including at counter = DIVIDE-1 or DIVIDE/2-1, SHALL override the wrap and toggle; reset wins.
REQ-014 On the first edge after RESET deasserts, counter SHALL become 1.
REQ-015 Before the first reset edge, output values are undefined; no power-on initialiser is required.

Configuration
REQ-016 Macro CLOCK_DIV_TICK_EN SHALL control an extra port and nothing else.
- Defined: add output TICK_OUT (1 bit), a registered single-cycle high pulse in the cycle where counter = 0 after a wrap. TICK_OUT is 0 in reset and 0 in the first cycle after reset.
- Undefined: TICK_OUT and its logic are absent; all other behaviour is identical.

Structure
REQ-017 Package clock_div_pkg SHALL hold:
- DEFAULT_DIVIDE = 100000;
- DEFAULT_CNT_W = 17;
- a function computing the half-period terminal value DIVIDE/2-1.
REQ-018 Single flat module; no sub-module is warranted.
- one counter process;
- one output-flop process;
- an optional tick process under the macro.

Verification (1000 ns clock, RESET high for the first 10 edges)
REQ-019 Post-reset count: after RESET deasserts -> counter reads 1, 2, 3 on successive edges; CLK_10HZ_OUT stays 0 until counter = 50000.
REQ-020 Half-period toggle: run 50000 edges after reset -> CLK_10HZ_OUT rises at the edge where counter becomes 50000 (t = 50 ms after reset release).
REQ-021 Wrap: run to counter = 99999, then one edge -> counter = 0 and CLK_10HZ_OUT = 0; the next rise occurs exactly 100000 edges after the previous rise.
REQ-022 Reset mid-operation: assert RESET at counter = 99999, and separately at counter = 49999 -> next edge gives counter = 0 and CLK_10HZ_OUT = 0, with no toggle.
REQ-023 Long run and small DIVIDE: measure 10 output periods -> each is exactly 100000 input cycles with high time 50000. Rerun with DIVIDE = 4, CNT_W = 2 -> output pattern 0,0,1,1 repeating.
REQ-024 Tick option: with CLOCK_DIV_TICK_EN defined -> TICK_OUT is high for exactly one cycle per 100000 edges, coincident with counter = 0 after a wrap; it is never high in the first cycle after reset.
